// File: rtl/incdec_stack.sv
// LIFO stack of signed words with in-place compound updates on the top entry.
// Push post-increments the pointer, pop pre-decrements it.
module incdec_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     op_valid,
  input  logic [2:0]               op_code,
  input  logic [WIDTH-1:0]         operand,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SHL1 = 3'd2,
    OP_SHR  = 3'd3,
    OP_INC  = 3'd4,
    OP_DEC  = 3'd5
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             we;
  logic [AW-1:0]    widx;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] op_res;
  logic             op_ok;
  logic             has;
  logic             is_full;
  logic             shr_big;

  // At count==DEPTH the low pointer bits wrap to 0, so -1 still lands on DEPTH-1.
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign top_val = mem_q[top_idx];
  assign has     = (count_q != '0);
  assign is_full = (count_q == CW'(DEPTH));
  assign shr_big = (operand >= WIDTH'(WIDTH));

  assign top       = has ? top_val : '0;
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = !has;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  always_comb begin
    op_res = top_val;
    op_ok  = 1'b1;
    case (op_code)
      OP_ADD:  op_res = top_val + operand;
      OP_SUB:  op_res = top_val - operand;
      OP_SHL1: op_res = top_val << 1;
      OP_SHR:  op_res = shr_big ? '0 : (top_val >> operand[SW-1:0]);
      OP_INC:  op_res = top_val + WIDTH'(1);
      OP_DEC:  op_res = top_val - WIDTH'(1);
      default: op_ok  = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    widx    = count_q[AW-1:0];
    wdata   = push_data;
    if (push && pop && has) begin
      we   = 1'b1;
      widx = top_idx;
    end else if (push) begin
      if (!is_full) begin
        we      = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      if (has) count_d = count_q - CW'(1);
      else     udf_d   = 1'b1;
    end else if (op_valid) begin
      if (has) begin
        we    = op_ok;
        widx  = top_idx;
        wdata = op_res;
      end else begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[widx] <= wdata;
  end

endmodule

// File: tb/tb_incdec_stack.sv
// Bench for incdec_stack: queue-based reference model feeding a scoreboard.
// Directed sequences first, then randomized traffic with occasional resets.
module tb_incdec_stack;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          op_valid = 1'b0;
  logic [2:0]    op_code = '0;
  logic [W-1:0]  operand = '0;
  logic [W-1:0]  top;
  logic [CW-1:0] count;
  logic          full, empty, overflow, underflow;

  incdec_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .push_data(push_data), .op_valid(op_valid),
    .op_code(op_code), .operand(operand),
    .top(top), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] top;
    int           cnt;
    bit           full;
    bit           empty;
    bit           ovf;
    bit           udf;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] stk[$];
  bit           m_ovf, m_udf;
  int           errors = 0;
  int           checks = 0;

  function automatic exp_t snap();
    exp_t e;
    e.top   = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    e.cnt   = stk.size();
    e.full  = (stk.size() == D);
    e.empty = (stk.size() == 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Reference behaviour straight from the stack rules.
  task automatic model(input bit p, input bit q, input bit ov,
                       input int code, input logic [W-1:0] dat,
                       input logic [W-1:0] opnd);
    logic [W-1:0] t;
    if (p && q && stk.size() > 0) begin
      stk[stk.size()-1] = dat;
    end else if (p) begin
      if (stk.size() < D) stk.push_back(dat);
      else m_ovf = 1;
    end else if (q) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_udf = 1;
    end else if (ov) begin
      if (stk.size() == 0) m_udf = 1;
      else begin
        t = stk[stk.size()-1];
        case (code)
          0: t = t + opnd;
          1: t = t - opnd;
          2: t = t * 2;
          3: t = (opnd >= W) ? '0 : t / (64'd1 << opnd);
          4: t = t + 1;
          5: t = t - 1;
          default: ;
        endcase
        stk[stk.size()-1] = t;
      end
    end
  endtask

  // Monitor: the DUT presents state every cycle; compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("top", 64'(top), 64'(e.top));
        chk("count", 64'(count), 64'(e.cnt));
        chk("full", 64'(full), 64'(e.full));
        chk("empty", 64'(empty), 64'(e.empty));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("underflow", 64'(underflow), 64'(e.udf));
      end
    end
  end

  task automatic cmd(input bit p, input bit q, input bit ov,
                     input int code, input logic [W-1:0] dat,
                     input logic [W-1:0] opnd);
    @(negedge clk);
    push = p; pop = q; op_valid = ov;
    op_code = code[2:0]; push_data = dat; operand = opnd;
    @(posedge clk);
    model(p, q, ov, code, dat, opnd);
    sbq.push_back(snap());
  endtask

  // One-cycle reset; junk command held during it must be discarded.
  task automatic do_reset(input bit junk);
    @(negedge clk);
    rst = 1'b1;
    push = junk; pop = 1'b0; op_valid = junk;
    op_code = 3'd4; push_data = $urandom; operand = $urandom;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_top", 64'(top), 64'd0);
    chk("async_flags", 64'({overflow, underflow}), 64'd0);
    stk.delete();
    m_ovf = 0;
    m_udf = 0;
    @(posedge clk);
    sbq.push_back(snap());
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0; op_valid = 1'b0;
  endtask

  task automatic op(input int code, input logic [W-1:0] opnd);
    cmd(0, 0, 1, code, '0, opnd);
  endtask

  initial begin
    int r;
    logic [W-1:0] opnd;
    do_reset(0);

    for (int i = 0; i < 3; i++) cmd(1, 0, 0, 0, W'(i), '0);

    do_reset(0);
    for (int i = 10; i <= 18; i++) cmd(1, 0, 0, 0, W'(i), '0);
    repeat (8) cmd(0, 1, 0, 0, '0, '0);

    do_reset(0);
    cmd(1, 0, 0, 0, 99, '0);
    op(0, 1);
    op(2, 0);
    op(3, 2);
    op(3, 1);
    op(3, 40);

    cmd(1, 0, 0, 0, 32'hFFFF_FFFF, '0);
    op(4, 0);
    op(5, 0);
    op(1, 32'hFFFF_FFFF);
    op(6, 5);
    op(7, 5);

    do_reset(0);
    cmd(0, 1, 0, 0, '0, '0);
    op(4, 0);
    cmd(1, 0, 0, 0, 5, '0);

    do_reset(0);
    cmd(1, 0, 0, 0, 7, '0);
    cmd(1, 1, 1, 4, 3, '0);
    do_reset(1);
    cmd(1, 1, 0, 0, 42, '0);

    // Fill to full then push+pop: replace only, no overflow.
    do_reset(0);
    for (int i = 0; i < D; i++) cmd(1, 0, 0, 0, W'(100 + i), '0);
    cmd(1, 1, 0, 0, 55, '0);

    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      opnd = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 40))
                                         : W'($urandom);
      if (r < 2)       do_reset($urandom_range(0, 1) == 1);
      else if (r < 35) cmd(1, 0, 0, 0, $urandom, opnd);
      else if (r < 60) cmd(0, 1, $urandom_range(0, 1) == 1, 4, '0, opnd);
      else if (r < 68) cmd(1, 1, $urandom_range(0, 1) == 1, 0, $urandom, opnd);
      else             op($urandom_range(0, 7), opnd);
    end

    @(negedge clk);
    push = 0; pop = 0; op_valid = 0;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/incdec_stack.md
Name: incdec_stack

Overview:
- Synchronous LIFO stack for signed integers.
- Stack pointer moves with post-increment on push and pre-decrement on pop.
- Top-of-stack supports in-place compound updates: +=, -=, <<=1, >>=n, ++, --.
- Sits in the SystemVerilog frontend regression set as the sequential, register-holding counterpart to the combinational increment/decrement and compound-assignment checks, so the same operators are exercised in always_ff context.

Parameters:
- WIDTH, 32, data width in bits; arithmetic is modulo 2^WIDTH.
- DEPTH, 8, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- push  input  1  push push_data onto stack.
- pop  input  1  remove top entry.
- push_data  input  WIDTH  value to push.
- op_valid  input  1  apply op_code to the top entry.
- op_code  input  3  0 ADD, 1 SUB, 2 SHL1, 3 SHR, 4 INC, 5 DEC, 6/7 reserved.
- operand  input  WIDTH  right-hand operand for ADD, SUB, SHR.
- top  output  WIDTH  current top entry; 0 when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set on a rejected push.
- underflow  output  1  sticky; set on a rejected pop or op.

Behaviour:
- Reset (asynchronous, rst high):
  - count=0, overflow=0, underflow=0; top therefore reads 0.
  - Storage array is not cleared.
  - Reset mid-operation discards any in-flight command; the first edge after rst falls is a normal command edge.
- All commands are sampled on the rising edge of clk. Results are visible on top/count/flags one cycle later; no combinational input-to-output path.
- top = mem[count-1] when count>0, else 0. full and empty decode from count registers.
- Command priority per edge: push/pop first, then op. op_valid is ignored whenever push or pop is high.
- push only, not full: mem[count] <= push_data, count++.
- push only, full: no change, overflow <= 1.
- pop only, not empty: count--. The old entry is retained in storage but no longer visible.
- pop only, empty: no change, underflow <= 1.
- push and pop together:
  - count>0: replace top with push_data; count unchanged; no flags set, even when full.
  - count==0: behaves as push only.
- op_valid only, not empty: mem[count-1] updates per op_code:
  - ADD: += operand, wraps.
  - SUB: -= operand, wraps.
  - SHL1: <<= 1; MSB discarded, 0 shifted in.
  - SHR: logical >>= operand, with operand treated as unsigned. Any operand >= WIDTH yields 0. A 1-bit signed operand value of 1 means shift by 1, never -1.
  - INC: += 1, wraps.
  - DEC: -= 1, wraps.
  - Reserved codes 6/7: no change, no flag.
- op_valid only, empty: no change, underflow <= 1.
- Sticky flags clear only on reset.
- count never exceeds DEPTH and never goes below 0 under any input sequence.

Test Plan:
- Reset, push 0,1,2 on consecutive cycles -> count=3, top=2, empty=0, full=0; overflow=0, underflow=0.
- DEPTH=8: push 9 times (values 10..18) -> count=8, full=1, top=17, overflow=1. Then pop 8 times -> top steps 16..10, then 0; empty=1, underflow=0.
- Push 99, ADD operand 1, then SHL1 -> top 100, then 200. SHR operand 2 -> 50. SHR operand 1 -> 25. SHR operand 40 -> 0.
- WIDTH=32: push 0xFFFFFFFF, INC -> 0x00000000. DEC -> 0xFFFFFFFF. SUB operand 0xFFFFFFFF -> 0x00000000.
- Empty stack, assert pop then op_valid INC -> underflow=1, count=0, top=0. Push 5 -> top=5, underflow stays 1.
- Push 7, then push=1/pop=1 with push_data 3 and op_valid=1 INC on the same edge -> count=1, top=3 (op ignored). Assert rst mid-stream for one cycle -> count=0, flags 0, top=0.
